usequencer: RTL and testbench

Microprogram sequencer for the microprocessor's control section. It holds the control-store address register (CSAR) and computes the next microinstruction address from the MIR condition and jump fields, the IR opcode fields and the PSR flags. It stalls the microprogram while a memory access is pending and supports an external halt. It sits between the MIR and the control store and paces every microinstruction executed by the datapath.

---
 rtl/usequencer.sv | 87 ++++++++
 tb/tb_usequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/usequencer.sv
// usequencer: microprogram sequencer holding the CSAR and pacing the MIR.
// It picks the next address from COND/JUMPADDR, IR fields and flags, and stalls on memory or halt.
module usequencer #(
    parameter int DATAWIDTH_CSAR = 11,
    parameter int DATAWIDTH_COND = 3,
    parameter int DATAWIDTH_OP = 2,
    parameter int DATAWIDTH_OP3 = 6,
    parameter logic [DATAWIDTH_CSAR-1:0] DATA_CSAR_RESET = 11'd0
) (
    input  logic                      uSequencer_CLOCK_50,
    input  logic                      uSequencer_RESET_InLow,
    input  logic [DATAWIDTH_COND-1:0] uSequencer_COND_In,
    input  logic [DATAWIDTH_CSAR-1:0] uSequencer_JUMPADDR_In,
    input  logic [DATAWIDTH_OP-1:0]   uSequencer_OP_In,
    input  logic [DATAWIDTH_OP3-1:0]  uSequencer_OP3_In,
    input  logic                      uSequencer_IR13_In,
    input  logic [3:0]                uSequencer_PSR_NZVC_In,
    input  logic                      uSequencer_MemReq_In,
    input  logic                      uSequencer_MemAck_In,
    input  logic                      uSequencer_Halt_In,
    output logic [DATAWIDTH_CSAR-1:0] uSequencer_CSAddr_Out,
    output logic                      uSequencer_MIRLoad_Out,
    output logic                      uSequencer_Stall_Out,
    output logic [1:0]                uSequencer_State_Out
);
    typedef enum logic [1:0] {INIT = 2'b00, RUN = 2'b01, WAIT_MEM = 2'b10, HALT = 2'b11} state_t;

    state_t state_q, state_d;
    logic [DATAWIDTH_CSAR-1:0] csar_q, csar_d, na;
    logic mirload_q, mirload_d, take, step;
    logic [DATAWIDTH_COND-1:0] cond;
    logic req, ack, halt;

    assign cond = uSequencer_COND_In;
    assign req  = uSequencer_MemReq_In;
    assign ack  = uSequencer_MemAck_In;
    assign halt = uSequencer_Halt_In;

    always_comb begin
        take = (cond == 3'd1) ? uSequencer_PSR_NZVC_In[3] :
               (cond == 3'd2) ? uSequencer_PSR_NZVC_In[2] :
               (cond == 3'd3) ? uSequencer_PSR_NZVC_In[1] :
               (cond == 3'd4) ? uSequencer_PSR_NZVC_In[0] :
               (cond == 3'd5) ? uSequencer_IR13_In :
               (cond == 3'd6);
        na = (cond == 3'd7) ? {1'b1, uSequencer_OP_In, uSequencer_OP3_In, 2'b00} :
             take ? uSequencer_JUMPADDR_In : csar_q + 1'b1;
        state_d = state_q;
        step = 1'b0;
        case (state_q)
            INIT: state_d = RUN;
            RUN: begin
                if (req && !ack) begin
                    state_d = WAIT_MEM;
                end else begin
                    // a completing access still steps even when halt is requested
                    step = req || !halt;
                    state_d = halt ? HALT : RUN;
                end
            end
            WAIT_MEM: begin
                step = ack;
                state_d = ack ? (halt ? HALT : RUN) : WAIT_MEM;
            end
            HALT: state_d = halt ? HALT : RUN;
        endcase
        csar_d = step ? na : csar_q;
        mirload_d = step || (state_q == INIT);
    end

    always_ff @(posedge uSequencer_CLOCK_50 or negedge uSequencer_RESET_InLow) begin
        if (!uSequencer_RESET_InLow) begin
            state_q <= INIT;
            csar_q <= DATA_CSAR_RESET;
            mirload_q <= 1'b0;
        end else begin
            state_q <= state_d;
            csar_q <= csar_d;
            mirload_q <= mirload_d;
        end
    end

    assign uSequencer_CSAddr_Out  = csar_q;
    assign uSequencer_MIRLoad_Out = mirload_q;
    assign uSequencer_Stall_Out   = (state_q == WAIT_MEM) || (state_q == HALT);
    assign uSequencer_State_Out   = state_q;
endmodule

// File: tb/tb_usequencer.sv
// tb_usequencer: directed self-checking bench for the microprogram sequencer.
// Observed word is {state[1:0], stall, mirload, csaddr[10:0]}.
module tb_usequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] cond;
    logic [10:0] jump;
    logic [1:0] op;
    logic [5:0] op3;
    logic ir13;
    logic [3:0] nzvc;
    logic req, ack, halt;
    logic [10:0] csaddr;
    logic mirload, stall;
    logic [1:0] state;
    int compared = 0;
    int mismatched = 0;

    usequencer dut (
        .uSequencer_CLOCK_50(clk),
        .uSequencer_RESET_InLow(rst_n),
        .uSequencer_COND_In(cond),
        .uSequencer_JUMPADDR_In(jump),
        .uSequencer_OP_In(op),
        .uSequencer_OP3_In(op3),
        .uSequencer_IR13_In(ir13),
        .uSequencer_PSR_NZVC_In(nzvc),
        .uSequencer_MemReq_In(req),
        .uSequencer_MemAck_In(ack),
        .uSequencer_Halt_In(halt),
        .uSequencer_CSAddr_Out(csaddr),
        .uSequencer_MIRLoad_Out(mirload),
        .uSequencer_Stall_Out(stall),
        .uSequencer_State_Out(state)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {state, stall, mirload, csaddr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cond = 3'd0; jump = '0; op = '0; op3 = '0; ir13 = 1'b0;
        nzvc = 4'd0; req = 1'b0; ack = 1'b0; halt = 1'b0;
        tick(); tick();
        compared++;
        if (obs() !== {2'd0, 1'b0, 1'b0, 11'd0}) begin mismatched++; $display("FAIL reset_hold: got %h want %h", obs(), {2'd0, 1'b0, 1'b0, 11'd0}); end
        rst_n = 1'b1;
        #1;
        compared++;
        if (obs() !== {2'd0, 1'b0, 1'b0, 11'd0}) begin mismatched++; $display("FAIL reset_init: got %h want %h", obs(), {2'd0, 1'b0, 1'b0, 11'd0}); end
        tick();
        compared++;
        if (obs() !== {2'd1, 1'b0, 1'b1, 11'd0}) begin mismatched++; $display("FAIL reset_run: got %h want %h", obs(), {2'd1, 1'b0, 1'b1, 11'd0}); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            compared++;
            if (obs() !== {2'd1, 1'b0, 1'b1, 11'(i)}) begin mismatched++; $display("FAIL reset_seq%0d: got %h want %h", i, obs(), {2'd1, 1'b0, 1'b1, 11'(i)}); end
        end
    endtask

    task automatic test_branches();
        cond = 3'd6; jump = 11'd5; tick();
        compared++;
        if (csaddr !== 11'd5) begin mismatched++; $display("FAIL br_jmp5: got %h want %h", csaddr, 11'd5); end
        cond = 3'd2; jump = 11'h040; nzvc = 4'b0100; tick();
        compared++;
        if (csaddr !== 11'h040) begin mismatched++; $display("FAIL br_z_taken: got %h want %h", csaddr, 11'h040); end
        cond = 3'd6; jump = 11'd5; tick();
        cond = 3'd2; jump = 11'h040; nzvc = 4'b0000; tick();
        compared++;
        if (csaddr !== 11'd6) begin mismatched++; $display("FAIL br_z_not: got %h want %h", csaddr, 11'd6); end
        cond = 3'd5; jump = 11'h123; ir13 = 1'b1; tick();
        compared++;
        if (csaddr !== 11'h123) begin mismatched++; $display("FAIL br_ir13: got %h want %h", csaddr, 11'h123); end
        ir13 = 1'b0;
        cond = 3'd1; jump = 11'h010; nzvc = 4'b1000; tick();
        compared++;
        if (csaddr !== 11'h010) begin mismatched++; $display("FAIL br_n: got %h want %h", csaddr, 11'h010); end
        cond = 3'd3; jump = 11'h020; nzvc = 4'b0010; tick();
        compared++;
        if (csaddr !== 11'h020) begin mismatched++; $display("FAIL br_v: got %h want %h", csaddr, 11'h020); end
        cond = 3'd4; jump = 11'h030; nzvc = 4'b0001; tick();
        compared++;
        if (csaddr !== 11'h030) begin mismatched++; $display("FAIL br_c: got %h want %h", csaddr, 11'h030); end
        cond = 3'd4; jump = 11'h050; nzvc = 4'b1110; tick();
        compared++;
        if (csaddr !== 11'h031) begin mismatched++; $display("FAIL br_c_not: got %h want %h", csaddr, 11'h031); end
        nzvc = 4'd0;
    endtask

    task automatic test_decode();
        cond = 3'd7; op = 2'b10; op3 = 6'b010000; tick();
        compared++;
        if (obs() !== {2'd1, 1'b0, 1'b1, 11'h640}) begin mismatched++; $display("FAIL decode: got %h want %h", obs(), {2'd1, 1'b0, 1'b1, 11'h640}); end
        cond = 3'd0;
    endtask

    task automatic test_mem_wait();
        req = 1'b1; ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (obs() !== {2'd2, 1'b1, 1'b0, 11'h640}) begin mismatched++; $display("FAIL mem_wait%0d: got %h want %h", i, obs(), {2'd2, 1'b1, 1'b0, 11'h640}); end
        end
        ack = 1'b1; tick();
        compared++;
        if (obs() !== {2'd1, 1'b0, 1'b1, 11'h641}) begin mismatched++; $display("FAIL mem_ack: got %h want %h", obs(), {2'd1, 1'b0, 1'b1, 11'h641}); end
        tick();
        compared++;
        if (obs() !== {2'd1, 1'b0, 1'b1, 11'h642}) begin mismatched++; $display("FAIL mem_zero_wait: got %h want %h", obs(), {2'd1, 1'b0, 1'b1, 11'h642}); end
        req = 1'b0; ack = 1'b0;
    endtask

    task automatic test_halt();
        halt = 1'b1; tick(); tick();
        compared++;
        if (obs() !== {2'd3, 1'b1, 1'b0, 11'h642}) begin mismatched++; $display("FAIL halt_hold: got %h want %h", obs(), {2'd3, 1'b1, 1'b0, 11'h642}); end
        halt = 1'b0; tick();
        compared++;
        if (obs() !== {2'd1, 1'b0, 1'b0, 11'h642}) begin mismatched++; $display("FAIL halt_resume: got %h want %h", obs(), {2'd1, 1'b0, 1'b0, 11'h642}); end
        tick();
        compared++;
        if (obs() !== {2'd1, 1'b0, 1'b1, 11'h643}) begin mismatched++; $display("FAIL halt_step: got %h want %h", obs(), {2'd1, 1'b0, 1'b1, 11'h643}); end
        req = 1'b1; ack = 1'b0; tick();
        halt = 1'b1; tick();
        compared++;
        if (obs() !== {2'd2, 1'b1, 1'b0, 11'h643}) begin mismatched++; $display("FAIL halt_in_wait: got %h want %h", obs(), {2'd2, 1'b1, 1'b0, 11'h643}); end
        ack = 1'b1; tick();
        compared++;
        if (obs() !== {2'd3, 1'b1, 1'b1, 11'h644}) begin mismatched++; $display("FAIL halt_after_ack: got %h want %h", obs(), {2'd3, 1'b1, 1'b1, 11'h644}); end
        req = 1'b0; ack = 1'b0; halt = 1'b0; tick();
        compared++;
        if (obs() !== {2'd1, 1'b0, 1'b0, 11'h644}) begin mismatched++; $display("FAIL halt_release: got %h want %h", obs(), {2'd1, 1'b0, 1'b0, 11'h644}); end
        req = 1'b1; ack = 1'b1; halt = 1'b1; tick();
        compared++;
        if (obs() !== {2'd3, 1'b1, 1'b1, 11'h645}) begin mismatched++; $display("FAIL halt_ack_same: got %h want %h", obs(), {2'd3, 1'b1, 1'b1, 11'h645}); end
        req = 1'b0; ack = 1'b0; halt = 1'b0; tick();
    endtask

    task automatic test_wrap();
        cond = 3'd6; jump = 11'h7FF; tick();
        cond = 3'd0; tick();
        compared++;
        if (obs() !== {2'd1, 1'b0, 1'b1, 11'd0}) begin mismatched++; $display("FAIL wrap: got %h want %h", obs(), {2'd1, 1'b0, 1'b1, 11'd0}); end
    endtask

    task automatic test_reset_mid_wait();
        cond = 3'd6; jump = 11'h155; tick();
        req = 1'b1; ack = 1'b0; tick();
        compared++;
        if (obs() !== {2'd2, 1'b1, 1'b0, 11'h155}) begin mismatched++; $display("FAIL rmw_enter: got %h want %h", obs(), {2'd2, 1'b1, 1'b0, 11'h155}); end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (obs() !== {2'd0, 1'b0, 1'b0, 11'd0}) begin mismatched++; $display("FAIL rmw_async: got %h want %h", obs(), {2'd0, 1'b0, 1'b0, 11'd0}); end
        req = 1'b0; cond = 3'd0;
        tick();
        rst_n = 1'b1; tick();
        compared++;
        if (obs() !== {2'd1, 1'b0, 1'b1, 11'd0}) begin mismatched++; $display("FAIL rmw_restart: got %h want %h", obs(), {2'd1, 1'b0, 1'b1, 11'd0}); end
    endtask

    initial begin
        test_reset();
        test_branches();
        test_decode();
        test_mem_wait();
        test_halt();
        test_wrap();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
